// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one sram1024x32_wrapper port between two requesters, one access in flight
// Ports: p0_*/p1_* command in (req/wen/addr/wdata), gnt/done pulses out; rdata/err returned with done;
//        address/read_enable/write_enable/write_data out to the wrapper, read_data/sram_state back.
// Define SRAM_ARB_RR_EN for round-robin tie-break; otherwise port 0 always wins ties.
module sram_port_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_wen,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_done,
  input  logic              p1_req,
  input  logic              p1_wen,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [ADDR_W-1:0] address,
  output logic              read_enable,
  output logic              write_enable,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data,
  input  logic [1:0]        sram_state
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);
  localparam logic [1:0] FREE = 2'd0;
  localparam logic [1:0] ERROR = 2'd3;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t r_state, w_next;
  logic r_wen, r_id, r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic [CW-1:0] r_cnt;
  logic [1:0] r_gnt, r_done;
  logic w_pick1, w_grant, w_busy, w_abort, w_ok;
`ifdef SRAM_ARB_RR_EN
  logic r_last;
  assign w_pick1 = p1_req & (~p0_req | ~r_last);
  always_ff @(posedge clk) begin
    if (rst) r_last <= 1'b1;
    else if (w_grant) r_last <= w_pick1;
  end
`else
  assign w_pick1 = p1_req & ~p0_req;
`endif
  assign w_grant = (r_state == IDLE) && (p0_req || p1_req) && (sram_state == FREE);
  assign w_busy  = (r_state == ISSUE) || (r_state == WAIT);
  assign w_abort = w_busy && ((sram_state == ERROR) || (r_cnt == TMAX));
  // timeout/error take precedence over a normal completion in the same cycle
  assign w_ok    = (r_state == WAIT) && (sram_state == FREE) && !w_abort;
  always_comb begin
    w_next = w_grant ? ISSUE :
             (w_abort || w_ok) ? DONE :
             (r_state == ISSUE && sram_state != FREE) ? WAIT :
             (r_state == DONE) ? IDLE : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_wen   <= 1'b0;
      r_id    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
    end else begin
      r_state <= w_next;
      r_gnt   <= {w_grant & w_pick1, w_grant & ~w_pick1};
      r_done  <= {(w_abort | w_ok) & r_id, (w_abort | w_ok) & ~r_id};
      r_err   <= w_abort;
      r_cnt   <= w_grant ? '0 : (w_busy && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;
      if (w_ok && !r_wen) r_rdata <= read_data;
      if (w_grant) begin
        r_id    <= w_pick1;
        r_wen   <= w_pick1 ? p1_wen : p0_wen;
        r_addr  <= w_pick1 ? p1_addr : p0_addr;
        r_wdata <= w_pick1 ? p1_wdata : p0_wdata;
      end
    end
  end
  assign p0_gnt       = r_gnt[0];
  assign p1_gnt       = r_gnt[1];
  assign p0_done      = r_done[0];
  assign p1_done      = r_done[1];
  assign err          = r_err;
  assign rdata        = r_rdata;
  assign address      = r_addr;
  assign write_data   = r_wdata;
  assign read_enable  = w_busy & ~r_wen;
  assign write_enable = w_busy & r_wen;
endmodule
